neuron_mac_sequencer: RTL and testbench
=======================================

# neuron_mac_sequencer

Sequenced single-neuron evaluator for the fixed-point neural-network datapath. It holds a locally written bank of NumInputs weights plus one offset (bias). It accepts NumInputs input samples over a valid/ready stream and accumulates saturating fixed-point products. It then adds the offset and presents one result over a valid/ready output handshake. It replaces the externally sequenced multiply/add pair with an autonomous FSM, a parametrised depth, and sticky overflow reporting.

## Interface
- Width, 8, total bits of every fixed-point word (two's complement)
- Precision, 4, fractional bits; integer magnitude bits = Width-1-Precision
- NumInputs, 20, samples per evaluation (≥1); AW = clog2(NumInputs+1)
- CLK  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- CoeffWrEn  in  1  write strobe for coefficient bank
- CoeffAddr  in  AW  0..NumInputs-1 = weights, NumInputs = Offset; larger addresses ignored
- CoeffData  in  Width  coefficient value
- Start  in  1  begin an evaluation (accepted only in IDLE)
- InValid  in  1  input sample valid
- InDato  in  Width  input sample
- InReady  out  1  block accepts sample this cycle
- OutValid  out  1  result valid
- OutDato  out  Width  result
- OutReady  in  1  consumer accepts result
- Busy  out  1  high in every state except IDLE
- Error  out  1  sticky saturation flag for the current/last evaluation

## Operation
- FSM states: IDLE, ACCUM, BIAS, DONE.
- IDLE: if Start, then clear the accumulator, the sample counter and Error, and go to ACCUM.
- ACCUM: InReady=1. Each cycle with InValid&InReady, acc ← sat(acc + mul(InDato, W[cnt])) and cnt++. When the NumInputs-th sample is accepted, go to BIAS.
- BIAS: acc ← sat(acc + Offset), then go to DONE.
- DONE: OutValid=1 and OutDato=acc (post-activation, see Configuration). When OutReady, go to IDLE.
- mul: form the full 2·Width signed product, arithmetic-shift right by Precision (truncate toward −∞), then saturate to [−2^(Width−1), 2^(Width−1)−1].
- sat on add: compute at Width+1 bits, then clamp to the same range.
- Any clamp in mul or add sets Error. Error holds until the next accepted Start.
- Coefficient writes are honoured only in IDLE. Writes while Busy are dropped. A write and a Start in the same cycle: the write lands first, and the evaluation uses the new value.
- Start outside IDLE is ignored.

## Timing
- Reset values: all FSM/acc/cnt registers cleared, coefficient bank zero. InReady=0, OutValid=0, OutDato=0, Busy=0, Error=0.
- Start→InReady high: 1 cycle.
- Last accepted sample→OutValid: 2 cycles (BIAS, then DONE).
- Minimum evaluation time: NumInputs+3 cycles from Start to the first cycle IDLE can accept Start again (with OutReady held high).
- OutDato and OutValid are stable while OutValid=1 & OutReady=0. InReady=0 outside ACCUM.
- Reset mid-operation: immediate return to IDLE with all reset values. A partial result is never emitted.
- Busy is a registered state decode. OutDato is registered.

## Configuration
- NEURON_ACT_EN defined: ReLU on output. OutDato = (acc<0) ? 0 : acc. Latency unchanged, applied combinationally from acc into the output register path. A negative clamp does not set Error.
- NEURON_ACT_EN undefined: OutDato = acc, raw signed result.

## Structure
- neuron_pkg: FSM state enum, the functions computing the MAX/MIN saturation constants from Width, and the clog2 helper.
- One sub-module: neuron_fxp_mul, combinational saturating fixed-point multiplier with overflow output.
- The coefficient bank is a register array, not a RAM, to keep the async-reset clearing.

## Test plan
Bench uses Width=8, Precision=4 (1.0=16), NumInputs=3.
- Nominal: W=16,16,16, Offset=8; inputs 16,32,−16 → OutDato=40 (2.5), Error=0, OutValid 2 cycles after the 3rd sample.
- Saturation: W all 127, inputs 127,127,127 → OutDato=127, Error=1. The next Start clears Error, and a nominal run gives Error=0.
- Backpressure: hold OutReady=0 for 5 cycles in DONE → OutValid/OutDato are held, InReady=0, and a Start pulse plus a CoeffWrEn are both ignored.
- Bubbled input: the nominal vectors with InValid low 2 cycles between samples → OutDato=40. cnt advances only on accepted samples.
- Reset mid-ACCUM after 1 sample → all outputs 0 next cycle. A fresh Start with no coefficient loads yields OutDato=0.
- Activation: W=16 each, Offset=0, inputs −16,−16,−16 → OutDato=−48 (0xD0) without NEURON_ACT_EN, 0 with it. Error=0 in both.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constant helpers for the neuron MAC sequencer:
// FSM state encoding, saturation bounds and a clog2 helper.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int satMax(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int satMin(input int width);
    return -(1 << (width - 1));
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/neuron_fxp_mul.sv
// Combinational saturating fixed-point multiplier: full-width product,
// arithmetic shift by Precision (floor), clamp to Width with overflow flag.
module neuron_fxp_mul
  import neuron_pkg::*;
#(
  parameter int Width     = 8,
  parameter int Precision = 4
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] y,
  output logic             ovf
);

  localparam logic signed [2*Width-1:0] MaxVal = (2*Width)'(satMax(Width));
  localparam logic signed [2*Width-1:0] MinVal = (2*Width)'(satMin(Width));

  logic signed [2*Width-1:0] prod;
  logic signed [2*Width-1:0] shifted;

  // Sign-extended operands keep the low 2*Width product bits exact
  always_comb begin
    prod    = $signed({{Width{a[Width-1]}}, a} * {{Width{b[Width-1]}}, b});
    shifted = prod >>> Precision;
    y       = shifted[Width-1:0];
    ovf     = 1'b0;
    if (shifted > MaxVal) begin
      y   = MaxVal[Width-1:0];
      ovf = 1'b1;
    end else if (shifted < MinVal) begin
      y   = MinVal[Width-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron evaluator: weight/offset bank, streamed saturating MAC, bias add.
// Optional ReLU on the result when NEURON_ACT_EN is defined.
module neuron_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int  Width     = 8,
  parameter int  Precision = 4,
  parameter int  NumInputs = 20,
  localparam int AW        = clog2(NumInputs + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             CoeffWrEn,
  input  logic [AW-1:0]    CoeffAddr,
  input  logic [Width-1:0] CoeffData,
  input  logic             Start,
  input  logic             InValid,
  input  logic [Width-1:0] InDato,
  output logic             InReady,
  output logic             OutValid,
  output logic [Width-1:0] OutDato,
  input  logic             OutReady,
  output logic             Busy,
  output logic             Error
);

  localparam logic [Width-1:0] MaxW = Width'(satMax(Width));
  localparam logic [Width-1:0] MinW = Width'(satMin(Width));

  state_t           state, nextState;
  logic [Width-1:0] weights [NumInputs];
  logic [Width-1:0] offset;
  logic [Width-1:0] acc;
  logic [Width-1:0] outReg;
  logic [AW-1:0]    cnt;
  logic             err;
  logic             busyReg;
  logic             validReg;
  logic [Width-1:0] mulY;
  logic             mulOvf;
  logic [Width:0]   accSum;
  logic [Width:0]   biasSum;
  logic [Width-1:0] actOut;
  logic             sample;
  logic             lastSample;

  // Returns {overflow, clamped sum} of two signed words
  function automatic logic [Width:0] satAdd(input logic [Width-1:0] x, input logic [Width-1:0] y);
    logic [Width:0] s;
    s = {x[Width-1], x} + {y[Width-1], y};
    if (s[Width] != s[Width-1]) return {1'b1, (s[Width] ? MinW : MaxW)};
    return {1'b0, s[Width-1:0]};
  endfunction

  neuron_fxp_mul #(.Width(Width), .Precision(Precision)) u_mul (
    .a   (InDato),
    .b   (weights[cnt]),
    .y   (mulY),
    .ovf (mulOvf)
  );

  assign sample     = InValid && (state == ACCUM);
  assign lastSample = sample && (cnt == AW'(NumInputs - 1));

  always_comb begin
    accSum  = satAdd(acc, mulY);
    biasSum = satAdd(acc, offset);
`ifdef NEURON_ACT_EN
    actOut  = biasSum[Width-1] ? '0 : biasSum[Width-1:0];
`else
    actOut  = biasSum[Width-1:0];
`endif
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = ACCUM;
      ACCUM:   if (lastSample) nextState = BIAS;
      BIAS:    nextState = DONE;
      DONE:    if (OutReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Busy/OutValid are registered from the next state so they track the state register exactly
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busyReg  <= 1'b0;
      validReg <= 1'b0;
    end else begin
      state    <= nextState;
      busyReg  <= (nextState != IDLE);
      validReg <= (nextState == DONE);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumInputs; i++) weights[i] <= '0;
      offset <= '0;
      acc    <= '0;
      outReg <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      // Bank writes land in IDLE, so a same-cycle Start already sees the new value
      if (state == IDLE && CoeffWrEn) begin
        if (CoeffAddr < AW'(NumInputs)) weights[CoeffAddr] <= CoeffData;
        else if (CoeffAddr == AW'(NumInputs)) offset <= CoeffData;
      end
      case (state)
        IDLE: if (Start) begin
          acc <= '0;
          cnt <= '0;
          err <= 1'b0;
        end
        ACCUM: if (sample) begin
          acc <= accSum[Width-1:0];
          cnt <= cnt + 1'b1;
          err <= err | mulOvf | accSum[Width];
        end
        BIAS: begin
          acc    <= biasSum[Width-1:0];
          err    <= err | biasSum[Width];
          outReg <= actOut;
        end
        default: ;
      endcase
    end
  end

  assign InReady  = (state == ACCUM);
  assign OutValid = validReg;
  assign OutDato  = outReg;
  assign Busy     = busyReg;
  assign Error    = err;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench for neuron_mac_sequencer against an arithmetic reference model.
// Expected results follow the NEURON_ACT_EN setting of the build.
module tb_neuron_mac_sequencer;

  localparam int Width     = 8;
  localparam int Precision = 4;
  localparam int NumInputs = 3;
  localparam int AW        = 2;

  logic             CLK = 1'b0;
  logic             reset;
  logic             CoeffWrEn;
  logic [AW-1:0]    CoeffAddr;
  logic [Width-1:0] CoeffData;
  logic             Start;
  logic             InValid;
  logic [Width-1:0] InDato;
  logic             InReady;
  logic             OutValid;
  logic [Width-1:0] OutDato;
  logic             OutReady;
  logic             Busy;
  logic             Error;

  int errors = 0;
  int checks = 0;
  int wModel [NumInputs+1];
  int xs [NumInputs];

  always #5 CLK = ~CLK;

  neuron_mac_sequencer #(.Width(Width), .Precision(Precision), .NumInputs(NumInputs)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .CoeffWrEn (CoeffWrEn),
    .CoeffAddr (CoeffAddr),
    .CoeffData (CoeffData),
    .Start     (Start),
    .InValid   (InValid),
    .InDato    (InDato),
    .InReady   (InReady),
    .OutValid  (OutValid),
    .OutDato   (OutDato),
    .OutReady  (OutReady),
    .Busy      (Busy),
    .Error     (Error)
  );

  // Reference: clamp to the signed 8-bit range and note any clamp
  function automatic int clampRef(input int v, inout bit e);
    if (v > 127) begin e = 1; return 127; end
    if (v < -128) begin e = 1; return -128; end
    return v;
  endfunction

  function automatic int floorDiv(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int modelEval(output bit e);
    int acc;
    e = 0;
    acc = 0;
    for (int i = 0; i < NumInputs; i++)
      acc = clampRef(acc + clampRef(floorDiv(xs[i] * wModel[i], 1 << Precision), e), e);
    acc = clampRef(acc + wModel[NumInputs], e);
`ifdef NEURON_ACT_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic writeCoeff(input int addr, input int data);
    CoeffWrEn = 1'b1;
    CoeffAddr = AW'(addr);
    CoeffData = Width'(data);
    @(negedge CLK);
    CoeffWrEn = 1'b0;
    wModel[addr] = data;
  endtask

  task automatic loadAll(input int w0, input int w1, input int w2, input int off);
    writeCoeff(0, w0);
    writeCoeff(1, w1);
    writeCoeff(2, w2);
    writeCoeff(3, off);
  endtask

  task automatic startEval();
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic sendSample(input int data, input int bubbles, output bit timedOut);
    bit taken;
    InValid  = 1'b1;
    InDato   = Width'(data);
    timedOut = 1'b1;
    for (int c = 0; c < 20; c++) begin
      taken = InReady;
      @(negedge CLK);
      if (taken) begin
        timedOut = 1'b0;
        break;
      end
    end
    InValid = 1'b0;
    repeat (bubbles) @(negedge CLK);
  endtask

  task automatic waitResult(output int cycles, output bit timedOut);
    cycles = 0;
    while (!OutValid && cycles < 20) begin
      @(negedge CLK);
      cycles++;
    end
    timedOut = !OutValid;
  endtask

  task automatic acceptResult();
    OutReady = 1'b1;
    @(negedge CLK);
    OutReady = 1'b0;
  endtask

  task automatic runEval(input int bubbles, output logic [Width-1:0] dato, output logic errOut,
                         output int latency, output bit timedOut);
    bit to;
    timedOut = 1'b0;
    startEval();
    for (int i = 0; i < NumInputs; i++) begin
      sendSample(xs[i], (i < NumInputs - 1) ? bubbles : 0, to);
      timedOut |= to;
    end
    waitResult(latency, to);
    timedOut |= to;
    dato   = OutDato;
    errOut = Error;
    acceptResult();
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    obs = {InReady, OutValid, Busy, Error, |OutDato};
    checks++;
    if (obs !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", obs);
    end
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || OutDato !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release: got busy=%b dato=%0d expected busy=0 dato=0", Busy, OutDato);
    end
  endtask

  task automatic test_nominal();
    logic [Width-1:0] dato;
    logic errOut;
    int lat, exp;
    bit to, e;
    loadAll(16, 16, 16, 8);
    xs = '{16, 32, -16};
    exp = modelEval(e);
    runEval(0, dato, errOut, lat, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL nominal_timeout: got timeout expected result"); end
    checks++;
    if (dato !== Width'(exp)) begin errors++; $display("[TB] FAIL nominal_dato: got %0d expected %0d", $signed(dato), exp); end
    checks++;
    if (errOut !== e) begin errors++; $display("[TB] FAIL nominal_error: got %b expected %b", errOut, e); end
    checks++;
    if (lat != 1) begin errors++; $display("[TB] FAIL nominal_latency: got %0d expected 1", lat); end
    checks++;
    if (Busy !== 1'b0 || OutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nominal_idle: got busy=%b valid=%b expected 0 0", Busy, OutValid);
    end
  endtask

  task automatic test_saturation();
    logic [Width-1:0] dato;
    logic errOut;
    int lat, exp;
    bit to, e;
    loadAll(127, 127, 127, 0);
    xs = '{127, 127, 127};
    exp = modelEval(e);
    runEval(0, dato, errOut, lat, to);
    checks++;
    if (to || dato !== Width'(exp)) begin errors++; $display("[TB] FAIL sat_dato: got %0d expected %0d", $signed(dato), exp); end
    checks++;
    if (errOut !== e) begin errors++; $display("[TB] FAIL sat_error: got %b expected %b", errOut, e); end
    loadAll(16, 16, 16, 8);
    xs = '{16, 32, -16};
    exp = modelEval(e);
    startEval();
    checks++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_clear: got error=%b busy=%b expected 0 1", Error, Busy);
    end
    for (int i = 0; i < NumInputs; i++) sendSample(xs[i], 0, to);
    waitResult(lat, to);
    checks++;
    if (to || OutDato !== Width'(exp) || Error !== e) begin
      errors++;
      $display("[TB] FAIL sat_followup: got dato=%0d err=%b expected %0d %b", $signed(OutDato), Error, exp, e);
    end
    acceptResult();
  endtask

  task automatic test_backpressure();
    logic [Width-1:0] dato;
    logic errOut;
    int lat, exp;
    bit to, e;
    xs = '{16, 32, -16};
    exp = modelEval(e);
    startEval();
    for (int i = 0; i < NumInputs; i++) sendSample(xs[i], 0, to);
    waitResult(lat, to);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (OutValid !== 1'b1 || OutDato !== Width'(exp) || InReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b dato=%0d ready=%b expected 1 %0d 0",
                 c, OutValid, $signed(OutDato), InReady, exp);
      end
      Start     = (c == 1);
      CoeffWrEn = (c == 2);
      CoeffAddr = '0;
      CoeffData = 8'd99;
      @(negedge CLK);
    end
    Start     = 1'b0;
    CoeffWrEn = 1'b0;
    acceptResult();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_start_ignored: got busy=%b expected 0", Busy); end
    runEval(0, dato, errOut, lat, to);
    checks++;
    if (to || dato !== Width'(exp)) begin
      errors++;
      $display("[TB] FAIL hold_write_dropped: got %0d expected %0d", $signed(dato), exp);
    end
  endtask

  task automatic test_bubbled();
    int lat, exp;
    bit to, e;
    xs = '{16, 32, -16};
    exp = modelEval(e);
    startEval();
    sendSample(xs[0], 2, to);
    sendSample(xs[1], 2, to);
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bubble_count: got ready=%b valid=%b expected 1 0", InReady, OutValid);
    end
    sendSample(xs[2], 0, to);
    waitResult(lat, to);
    checks++;
    if (to || lat != 1 || OutDato !== Width'(exp)) begin
      errors++;
      $display("[TB] FAIL bubble_dato: got %0d lat=%0d expected %0d lat=1", $signed(OutDato), lat, exp);
    end
    acceptResult();
  endtask

  task automatic test_reset_mid();
    logic [Width-1:0] dato;
    logic errOut;
    logic [4:0] obs;
    int lat, exp;
    bit to, e;
    loadAll(16, 16, 16, 8);
    startEval();
    sendSample(16, 0, to);
    reset = 1'b0;
    @(negedge CLK);
    obs = {InReady, OutValid, Busy, Error, |OutDato};
    checks++;
    if (obs !== 5'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got %b expected 00000", obs); end
    reset = 1'b1;
    for (int i = 0; i <= NumInputs; i++) wModel[i] = 0;
    @(negedge CLK);
    xs = '{16, 32, -16};
    exp = modelEval(e);
    runEval(0, dato, errOut, lat, to);
    checks++;
    if (to || dato !== Width'(exp) || errOut !== e) begin
      errors++;
      $display("[TB] FAIL midreset_cleared_bank: got %0d err=%b expected %0d %b", $signed(dato), errOut, exp, e);
    end
  endtask

  task automatic test_activation();
    logic [Width-1:0] dato;
    logic errOut;
    int lat, exp;
    bit to, e;
    loadAll(16, 16, 16, 0);
    xs = '{-16, -16, -16};
    exp = modelEval(e);
    runEval(0, dato, errOut, lat, to);
    checks++;
    if (to || dato !== Width'(exp)) begin errors++; $display("[TB] FAIL act_dato: got %0d expected %0d", $signed(dato), exp); end
    checks++;
    if (errOut !== e) begin errors++; $display("[TB] FAIL act_error: got %b expected %b", errOut, e); end
  endtask

  task automatic test_random();
    logic [Width-1:0] dato;
    logic errOut;
    int lat, exp, span;
    bit to, e;
    for (int n = 0; n < 12; n++) begin
      span = (n % 2 == 0) ? 40 : 128;
      for (int i = 0; i <= NumInputs; i++)
        writeCoeff(i, int'($urandom_range(0, 2 * span - 1)) - span);
      for (int i = 0; i < NumInputs; i++) xs[i] = int'($urandom_range(0, 2 * span - 1)) - span;
      exp = modelEval(e);
      runEval(int'($urandom_range(0, 2)), dato, errOut, lat, to);
      checks++;
      if (to || dato !== Width'(exp) || errOut !== e) begin
        errors++;
        $display("[TB] FAIL random%0d: got %0d err=%b expected %0d err=%b", n, $signed(dato), errOut, exp, e);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    CoeffWrEn = 1'b0;
    CoeffAddr = '0;
    CoeffData = '0;
    Start     = 1'b0;
    InValid   = 1'b0;
    InDato    = '0;
    OutReady  = 1'b0;
    for (int i = 0; i <= NumInputs; i++) wModel[i] = 0;
    repeat (2) @(negedge CLK);
    test_reset();
    test_nominal();
    test_saturation();
    test_backpressure();
    test_bubbled();
    test_reset_mid();
    test_activation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
